vred_unit: RTL and testbench
============================

VRED_UNIT -- requirements
Module: vred_unit

Interface
REQ-001 Parameter NUM_LANES, default 2, number of 64-bit lane results to reduce (VLEN/64); legal values 1..8.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rstn_i  input  1  reset, asynchronous, active-low.
REQ-004 valid_i  input  1  upstream holds a reduction request.
REQ-005 ready_o  output  1  unit accepts a request this cycle.
REQ-006 instr_type_i  input  instr_type_t  operation: VREDSUM, VREDAND, VREDOR or VREDXOR.
REQ-007 sew_i  input  sew_t  element width: SEW_8, SEW_16, SEW_32 or SEW_64.
REQ-008 data_lanes_i  input  NUM_LANES*64  functional-unit lane results; lane k at bits [64k+63:64k].
REQ-009 data_init_i  input  64  vs1 scalar operand; only bits [SEW-1:0] are used.
REQ-010 kill_i  input  1  flush; aborts any request in flight.
REQ-011 valid_o  output  1  result available.
REQ-012 ready_i  input  1  downstream accepts the result.
REQ-013 data_vd_o  output  64  reduction result, zero-extended above SEW.

Function
REQ-014 FSM states: IDLE, LANE, FOLD, DONE; ready_o SHALL be 1 only in IDLE; valid_o SHALL be 1 only in DONE.
REQ-015 IDLE: when valid_i=1 and kill_i=0, the unit SHALL capture instr_type_i, sew_i, data_lanes_i and data_init_i, load acc with lane 0 and lane index with 1, and go to LANE (FOLD if NUM_LANES=1).
REQ-016 LANE: each cycle, acc SHALL become op(acc, lane[index]) elementwise at SEW, and index SHALL increment; after lane NUM_LANES-1 is combined the FSM SHALL go to FOLD.
REQ-017 FOLD, width w starting at 64: while w>SEW, acc[w/2-1:0] SHALL become op(acc[w/2-1:0], acc[w-1:w/2]) and w SHALL halve, one step per cycle.
REQ-018 FOLD, when w=SEW: acc[SEW-1:0] SHALL become op(acc[SEW-1:0], init[SEW-1:0]), acc above SEW SHALL be zeroed, and the FSM SHALL go to DONE.
REQ-019 op definitions:
- VREDSUM: per-element add, modulo 2^SEW, no carry across element boundaries.
- VREDAND, VREDOR, VREDXOR: bitwise.
REQ-020 Any other captured instr_type SHALL follow the same state sequence and SHALL produce data_vd_o=0.
REQ-021 Latency from accept edge to valid_o=1 SHALL be (NUM_LANES-1)+log2(64/SEW)+1 cycles; for NUM_LANES=2 this is SEW_8=5, SEW_16=4, SEW_32=3, SEW_64=2.
REQ-022 DONE: data_vd_o=acc; valid_o and data_vd_o SHALL stay stable until ready_i=1, then the FSM SHALL return to IDLE on the next edge.
REQ-023 Back-to-back: a new request SHALL NOT be accepted in the same cycle a result is consumed; the earliest accept is the following cycle in IDLE.
REQ-024 kill_i=1 in any state SHALL force IDLE on the next edge and drop the result; in IDLE, kill_i SHALL have priority over valid_i, so no capture occurs.
REQ-025 Captured operands SHALL be unaffected by changes on the inputs after the accept edge.
REQ-026 Outside DONE, data_vd_o SHALL be 0.

Reset
REQ-027 With rstn_i=0, the unit SHALL immediately, without waiting for clk_i, enter IDLE with acc=0, index=0, w=64, valid_o=0, ready_o=1 and data_vd_o=0.
REQ-028 Reset asserted mid-operation SHALL discard the request; after release, valid_o SHALL stay 0 until a new request completes.

Verification (NUM_LANES=2)
REQ-029 Sum with init: VREDSUM, SEW_8, lane0=0x0807060504030201, lane1=0x0101010101010101, init=0x05 -> valid_o 5 cycles after accept, data_vd_o=0x31.
REQ-030 Element wrap: VREDSUM, SEW_8, both lanes all-ones, init=0x01 -> data_vd_o=0xF1, upper 56 bits 0.
REQ-031 AND at SEW_64:
- Stimulus: VREDAND, lane0=0xFFFF0000FFFF0000, lane1=0x0F0F0F0F0F0F0F0F, init=all-ones.
- Response: valid_o 2 cycles after accept, data_vd_o=0x0F0F00000F0F0000.
REQ-032 Backpressure:
- Stimulus: ready_i=0 for 3 cycles in DONE, valid_i held 1.
- Response: valid_o and data_vd_o stable, ready_o=0, no new capture; IDLE one cycle after ready_i=1.
REQ-033 Flush:
- Stimulus: kill_i pulse during FOLD of a SEW_8 request.
- Response: next cycle ready_o=1, valid_o never asserted for that request; a following request completes normally.
REQ-034 Async reset mid-LANE:
- Stimulus: rstn_i low between clock edges.
- Response: ready_o=1 and valid_o=0 before the next edge; no stale result after release.

Source files
------------

// File: rtl/vred_unit.sv
// Vector reduction unit: folds NUM_LANES 64-bit lane results and a scalar init
// into one SEW-wide element (sum, and, or, xor).

typedef enum logic [2:0] {
  VREDSUM = 3'd0,
  VREDAND = 3'd1,
  VREDOR  = 3'd2,
  VREDXOR = 3'd3
} instr_type_t;

typedef enum logic [1:0] {
  SEW_8  = 2'd0,
  SEW_16 = 2'd1,
  SEW_32 = 2'd2,
  SEW_64 = 2'd3
} sew_t;

// state | meaning
// IDLE  | waiting for a request, ready_o high
// LANE  | combining lane[idx] into acc, one lane per cycle
// FOLD  | halving acc width down to SEW, then folding in init
// DONE  | result held on data_vd_o until ready_i
module vred_unit #(
  parameter int NUM_LANES = 2
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  instr_type_t               instr_type_i,
  input  sew_t                      sew_i,
  input  logic [NUM_LANES*64-1:0]   data_lanes_i,
  input  logic [63:0]               data_init_i,
  input  logic                      kill_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [63:0]               data_vd_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LANE = 2'd1,
    S_FOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_LANES - 1);

  state_t                    state_q, state_d;
  instr_type_t               instr_q, instr_d;
  sew_t                      sew_q, sew_d;
  logic [NUM_LANES*64-1:0]   lanes_q, lanes_d;
  logic [63:0]               init_q, init_d;
  logic [63:0]               acc_q, acc_d;
  logic [3:0]                idx_q, idx_d;
  // Current fold width encoded like sew_t: 3 = 64 bits ... 0 = 8 bits
  logic [1:0]                w_q, w_d;

  logic [63:0] lane_sel;
  logic [63:0] sew_m;
  logic [63:0] half_m;
  logic [63:0] fold_hi;
  logic [63:0] fold_res;

  function automatic logic [63:0] mask_of(input logic [1:0] code);
    logic [63:0] m;
    case (code)
      2'd0:    m = 64'h0000_0000_0000_00FF;
      2'd1:    m = 64'h0000_0000_0000_FFFF;
      2'd2:    m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

  // Elementwise at SEW: adds never carry across element boundaries
  function automatic logic [63:0] op_f(input instr_type_t t, input sew_t s,
                                       input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    r = '0;
    case (t)
      VREDSUM: begin
        case (s)
          SEW_8:   for (int i = 0; i < 8; i++) r[8*i +: 8]   = a[8*i +: 8]   + b[8*i +: 8];
          SEW_16:  for (int i = 0; i < 4; i++) r[16*i +: 16] = a[16*i +: 16] + b[16*i +: 16];
          SEW_32:  for (int i = 0; i < 2; i++) r[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
          default: r = a + b;
        endcase
      end
      VREDAND: r = a & b;
      VREDOR:  r = a | b;
      VREDXOR: r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    lane_sel = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (idx_q == 4'(k)) lane_sel = lanes_q[k*64 +: 64];
    end
  end

  always_comb begin
    sew_m  = mask_of(sew_q);
    half_m = mask_of(w_q - 2'd1);
    case (w_q)
      2'd3:    fold_hi = {32'b0, acc_q[63:32]};
      2'd2:    fold_hi = {48'b0, acc_q[31:16]};
      2'd1:    fold_hi = {56'b0, acc_q[15:8]};
      default: fold_hi = '0;
    endcase
    fold_res = op_f(instr_q, sew_q, acc_q & half_m, fold_hi);
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    sew_d     = sew_q;
    lanes_d   = lanes_q;
    init_d    = init_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    w_d       = w_q;
    ready_o   = 1'b0;
    valid_o   = 1'b0;
    data_vd_o = '0;

    case (state_q)
      S_IDLE: begin
        ready_o = 1'b1;
        if (valid_i && !kill_i) begin
          instr_d = instr_type_i;
          sew_d   = sew_i;
          lanes_d = data_lanes_i;
          init_d  = data_init_i;
          acc_d   = data_lanes_i[63:0];
          idx_d   = 4'd1;
          w_d     = 2'd3;
          state_d = (NUM_LANES == 1) ? S_FOLD : S_LANE;
        end
      end
      S_LANE: begin
        acc_d = op_f(instr_q, sew_q, acc_q, lane_sel);
        idx_d = idx_q + 4'd1;
        if (idx_q == LAST_IDX) state_d = S_FOLD;
      end
      S_FOLD: begin
        if (w_q > sew_q) begin
          acc_d = (acc_q & ~half_m) | (fold_res & half_m);
          w_d   = w_q - 2'd1;
        end else begin
          acc_d   = op_f(instr_q, sew_q, acc_q & sew_m, init_q & sew_m) & sew_m;
          state_d = S_DONE;
        end
      end
      default: begin
        valid_o   = 1'b1;
        data_vd_o = acc_q;
        if (ready_i) state_d = S_IDLE;
      end
    endcase

    if (kill_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      instr_q <= VREDSUM;
      sew_q   <= SEW_8;
      lanes_q <= '0;
      init_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      w_q     <= 2'd3;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      sew_q   <= sew_d;
      lanes_q <= lanes_d;
      init_q  <= init_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      w_q     <= w_d;
    end
  end

endmodule

// File: tb/tb_vred_unit.sv
// Scoreboard bench for vred_unit (NUM_LANES=2): driver pushes expected result
// and latency, monitor pops and compares whenever valid_o rises.

module tb_vred_unit;

  logic          clk;
  logic          rstn;
  logic          valid_i;
  logic          ready_o;
  instr_type_t   instr;
  sew_t          sew;
  logic [127:0]  lanes;
  logic [63:0]   init;
  logic          kill;
  logic          valid_o;
  logic          ready_i;
  logic [63:0]   vd;

  typedef struct {
    logic [63:0] data;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   seen  = 0;
  logic [63:0] hold;

  vred_unit #(.NUM_LANES(2)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .instr_type_i (instr),
    .sew_i        (sew),
    .data_lanes_i (lanes),
    .data_init_i  (init),
    .kill_i       (kill),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .data_vd_o    (vd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor
  initial forever begin
    @(negedge clk);
    if (rstn) begin
      if (valid_o && !seen) begin
        seen = 1'b1;
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_result: data_vd_o=%h, required no valid_o", vd);
        end else begin
          mon_e = sbq.pop_front();
          check("result_data", vd, mon_e.data);
          check("result_latency", 64'(cyc - mon_e.acc_cyc), 64'(mon_e.lat));
          check("ready_in_done", 64'(ready_o), 64'd0);
        end
      end
      if (!valid_o) begin
        seen = 1'b0;
        check("vd_zero_outside_done", vd, 64'd0);
      end
    end
  end

  task automatic drive(input instr_type_t t, input sew_t s,
                       input logic [63:0] l0, input logic [63:0] l1, input logic [63:0] in);
    instr = t;
    sew   = s;
    lanes = {l1, l0};
    init  = in;
  endtask

  task automatic scramble();
    lanes = {$urandom(), $urandom(), $urandom(), $urandom()};
    init  = {$urandom(), $urandom()};
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 64'(ready_o), 64'd1);
  endtask

  task automatic push_exp(input logic [63:0] d, input int lat);
    exp_t e;
    e.data    = d;
    e.lat     = lat;
    e.acc_cyc = cyc;
    sbq.push_back(e);
  endtask

  task automatic send(input instr_type_t t, input sew_t s,
                      input logic [63:0] l0, input logic [63:0] l1, input logic [63:0] in,
                      input logic [63:0] exp_d, input int lat);
    @(negedge clk);
    drive(t, s, l0, l1, in);
    valid_i = 1'b1;
    wait_ready();
    @(posedge clk);
    #1;
    push_exp(exp_d, lat);
    valid_i = 1'b0;
    scramble();
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 64'(sbq.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    rstn    = 1'b0;
    valid_i = 1'b0;
    kill    = 1'b0;
    ready_i = 1'b1;
    instr   = VREDSUM;
    sew     = SEW_8;
    lanes   = '0;
    init    = '0;

    #2;
    check("reset_ready_o", 64'(ready_o), 64'd1);
    check("reset_valid_o", 64'(valid_o), 64'd0);
    check("reset_data_vd_o", vd, 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Back-to-back directed vectors
    send(VREDSUM, SEW_8,  64'h0807060504030201, 64'h0101010101010101, 64'h05, 64'h31, 5);
    send(VREDSUM, SEW_8,  64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hABCDEF0000000001, 64'hF1, 5);
    send(VREDAND, SEW_64, 64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F, 64'hFFFFFFFFFFFFFFFF,
         64'h0F0F00000F0F0000, 2);
    send(VREDOR,  SEW_16, 64'h0001000200040008, 64'h0010002000400080, 64'h0100, 64'h01FF, 4);
    send(VREDXOR, SEW_32, 64'h123456780000FFFF, 64'h0000FFFFFFFF0000, 64'hAAAAAAAA000000FF,
         64'hEDCB5687, 3);
    send(VREDSUM, SEW_16, 64'h8000800080008000, 64'h0001000100010001, 64'h0003, 64'h0007, 4);
    send(VREDSUM, SEW_32, 64'h00000001FFFFFFFF, 64'h0000000200000001, 64'h5, 64'h8, 3);
    send(VREDSUM, SEW_64, 64'hFFFFFFFFFFFFFFFF, 64'h2, 64'h3, 64'h4, 2);
    send(instr_type_t'(3'd5), SEW_8, 64'h1122334455667788, 64'h99AABBCCDDEEFF00, 64'h7F, 64'h0, 5);
    drain();

    // Backpressure with a new request held on valid_i
    ready_i = 1'b0;
    send(VREDAND, SEW_64, 64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F, 64'hFFFFFFFFFFFFFFFF,
         64'h0F0F00000F0F0000, 2);
    drive(VREDOR, SEW_16, 64'h0001000200040008, 64'h0010002000400080, 64'h0100);
    valid_i = 1'b1;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!valid_o && n < 20);
    end
    check("bp_valid_seen", 64'(valid_o), 64'd1);
    hold = vd;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid_stable", 64'(valid_o), 64'd1);
      check("bp_data_stable", vd, hold);
      check("bp_ready_low", 64'(ready_o), 64'd0);
    end
    ready_i = 1'b1;
    @(negedge clk);
    check("bp_idle_ready", 64'(ready_o), 64'd1);
    check("bp_idle_valid", 64'(valid_o), 64'd0);
    @(posedge clk);
    #1;
    push_exp(64'h01FF, 4);
    valid_i = 1'b0;
    scramble();
    drain();

    // Flush during FOLD
    @(negedge clk);
    drive(VREDSUM, SEW_8, 64'h0807060504030201, 64'h0101010101010101, 64'h05);
    valid_i = 1'b1;
    wait_ready();
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("flush_ready", 64'(ready_o), 64'd1);
    check("flush_valid", 64'(valid_o), 64'd0);
    repeat (8) @(negedge clk);

    // Kill has priority over valid_i in IDLE
    drive(VREDOR, SEW_64, 64'h1, 64'h2, 64'h4);
    valid_i = 1'b1;
    kill    = 1'b1;
    @(negedge clk);
    check("kill_idle_no_capture", 64'(ready_o), 64'd1);
    valid_i = 1'b0;
    kill    = 1'b0;
    repeat (6) @(negedge clk);
    send(VREDSUM, SEW_8, 64'h0807060504030201, 64'h0101010101010101, 64'h05, 64'h31, 5);
    drain();

    // Asynchronous reset mid-LANE
    @(negedge clk);
    drive(VREDXOR, SEW_32, 64'h123456780000FFFF, 64'h0000FFFFFFFF0000, 64'hFF);
    valid_i = 1'b1;
    wait_ready();
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check("arst_ready", 64'(ready_o), 64'd1);
    check("arst_valid", 64'(valid_o), 64'd0);
    check("arst_data", vd, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (8) @(negedge clk);
    send(VREDSUM, SEW_16, 64'h8000800080008000, 64'h0001000100010001, 64'h0003, 64'h0007, 4);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
